addr_trans: RTL and testbench

- Virtual-to-physical address translation stage in front of the shared `tlb` block.
- Drives one `tlb` search port (s0 for fetch, s1 for load/store; one instance per port).
- Selects among direct-address mode, DMW0/DMW1 direct-mapped windows, and TLB-mapped translation.
- Returns the PA, MAT and the translation exception through a 2-deep valid/ready pipeline.

---
 rtl/addr_trans_pkg.sv | 27 ++
 rtl/addr_trans_if.sv | 24 ++
 rtl/addr_trans_dmw_match.sv | 22 ++
 rtl/addr_trans.sv | 128 ++++++++++++
 tb/tb_addr_trans.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr_trans_pkg.sv
// addr_trans_pkg: shared encodings and CSR field positions for address translation
package addr_trans_pkg;

    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    typedef enum logic [2:0] {
        EXC_NONE = 3'd0,
        EXC_TLBR = 3'd1,
        EXC_PIL  = 3'd2,
        EXC_PIS  = 3'd3,
        EXC_PIF  = 3'd4,
        EXC_PME  = 3'd5,
        EXC_PPI  = 3'd6
    } exc_e;

    localparam int DMW_PLV0    = 0;
    localparam int DMW_PLV3    = 3;
    localparam int DMW_MAT_LO  = 4;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_VSEG_LO = 29;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd22;

endpackage

// File: rtl/addr_trans_if.sv
// addr_trans_if: request/response handshake bundle between a requester and the translator
interface addr_trans_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_va;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pa;
    logic [1:0]  rsp_mat;
    logic [2:0]  rsp_exc;

    modport master (
        output req_valid, req_va, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc
    );

    modport slave (
        input  req_valid, req_va, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_pa, rsp_mat, rsp_exc
    );

endinterface

// File: rtl/addr_trans_dmw_match.sv
// dmw_match: one direct-mapped window lookup; privilege only honoured at PLV0 and PLV3
module dmw_match
    import addr_trans_pkg::*;
(
    input  logic [31:0] dmw,
    input  logic [1:0]  plv,
    input  logic [2:0]  vseg,
    output logic        hit,
    output logic [2:0]  pseg,
    output logic [1:0]  mat
);

    logic plv_ok;
    logic unused_dmw;

    assign plv_ok     = plv == 2'd0 ? dmw[DMW_PLV0] : plv == 2'd3 ? dmw[DMW_PLV3] : 1'b0;
    assign hit        = plv_ok && dmw[DMW_VSEG_LO +: 3] == vseg;
    assign pseg       = dmw[DMW_PSEG_LO +: 3];
    assign mat        = dmw[DMW_MAT_LO +: 2];
    assign unused_dmw = ^{dmw[2:1], dmw[24:6], dmw[28]};

endmodule

// File: rtl/addr_trans.sv
// addr_trans: VA->PA translation stage (DA / DMW / TLB) with a 2-deep valid/ready pipeline
module addr_trans
    import addr_trans_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    addr_trans_if.slave  bus,
    input  logic         csr_crmd_da,
    input  logic         csr_crmd_pg,
    input  logic [1:0]   csr_crmd_plv,
    input  logic [1:0]   csr_crmd_datf,
    input  logic [1:0]   csr_crmd_datm,
    input  logic [9:0]   csr_asid,
    input  logic [31:0]  csr_dmw0,
    input  logic [31:0]  csr_dmw1,
    output logic [18:0]  s_vppn,
    output logic         s_va_bit12,
    output logic [9:0]   s_asid,
    input  logic         s_found,
    input  logic [19:0]  s_ppn,
    input  logic [5:0]   s_ps,
    input  logic [1:0]   s_plv,
    input  logic [1:0]   s_mat,
    input  logic         s_d,
    input  logic         s_v
);

    logic        s1_valid;
    logic [31:0] s1_va;
    logic [1:0]  s1_op;
    logic        s2_valid;
    logic [31:0] s2_pa;
    logic [1:0]  s2_mat;
    exc_e        s2_exc;

    logic        s1_adv, s2_adv, req_ready;
    logic        d0_hit, d1_hit;
    logic [2:0]  d0_pseg, d1_pseg;
    logic [1:0]  d0_mat, d1_mat;
    logic        is_fetch, is_store;
    exc_e        tlb_exc, exc;
    logic [31:0] tlb_pa, raw_pa, pa;
    logic [1:0]  raw_mat, mat;

    dmw_match u_dmw0 (
        .dmw  (csr_dmw0),
        .plv  (csr_crmd_plv),
        .vseg (s1_va[31:29]),
        .hit  (d0_hit),
        .pseg (d0_pseg),
        .mat  (d0_mat)
    );

    dmw_match u_dmw1 (
        .dmw  (csr_dmw1),
        .plv  (csr_crmd_plv),
        .vseg (s1_va[31:29]),
        .hit  (d1_hit),
        .pseg (d1_pseg),
        .mat  (d1_mat)
    );

    assign s2_adv        = !s2_valid || bus.rsp_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign req_ready     = s1_adv && !flush;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_pa    = s2_pa;
    assign bus.rsp_mat   = s2_mat;
    assign bus.rsp_exc   = s2_exc;
    assign s_vppn        = s1_va[31:13];
    assign s_va_bit12    = s1_va[12];
    assign s_asid        = csr_asid;

    // Resolve the S1 request: DA beats DMW0 beats DMW1 beats TLB; any exception zeroes PA/MAT
    always_comb begin
        is_fetch = s1_op == OP_FETCH;
        is_store = s1_op == OP_STORE;
        tlb_exc  = !s_found ? EXC_TLBR :
                   !s_v ? (is_fetch ? EXC_PIF : is_store ? EXC_PIS : EXC_PIL) :
                   csr_crmd_plv > s_plv ? EXC_PPI :
                   is_store && !s_d ? EXC_PME : EXC_NONE;
        tlb_pa   = s_ps == PS_4M ? {s_ppn[19:10], s1_va[21:0]} : {s_ppn, s1_va[11:0]};
        exc      = csr_crmd_da || (csr_crmd_pg && (d0_hit || d1_hit)) ? EXC_NONE : tlb_exc;
        raw_pa   = csr_crmd_da ? s1_va :
                   csr_crmd_pg && d0_hit ? {d0_pseg, s1_va[28:0]} :
                   csr_crmd_pg && d1_hit ? {d1_pseg, s1_va[28:0]} : tlb_pa;
        raw_mat  = csr_crmd_da ? (is_fetch ? csr_crmd_datf : csr_crmd_datm) :
                   csr_crmd_pg && d0_hit ? d0_mat :
                   csr_crmd_pg && d1_hit ? d1_mat : s_mat;
        pa       = exc != EXC_NONE ? 32'd0 : raw_pa;
        mat      = exc != EXC_NONE ? 2'd0 : raw_mat;
    end

    // S1: capture accepted requests; flush empties the stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_va    <= 32'd0;
            s1_op    <= OP_FETCH;
        end else begin
            s1_valid <= flush ? 1'b0 : s1_adv ? bus.req_valid : s1_valid;
            if (bus.req_valid && req_ready) begin
                s1_va <= bus.req_va;
                s1_op <= bus.req_op;
            end
        end
    end

    // S2: register the translation result and hold it while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_pa    <= 32'd0;
            s2_mat   <= 2'd0;
            s2_exc   <= EXC_NONE;
        end else begin
            s2_valid <= flush ? 1'b0 : s2_adv ? s1_valid : s2_valid;
            if (s2_adv && s1_valid) begin
                s2_pa  <= pa;
                s2_mat <= mat;
                s2_exc <= exc;
            end
        end
    end

endmodule

// File: tb/tb_addr_trans.sv
// tb_addr_trans: scoreboard bench for addr_trans with a behavioural translation model and TLB stub
module tb_addr_trans;

    logic        clk, reset, flush;
    logic        c_da, c_pg;
    logic [1:0]  c_plv, c_datf, c_datm;
    logic [9:0]  c_asid;
    logic [31:0] c_dmw0, c_dmw1;
    logic [18:0] s_vppn;
    logic        s_va_bit12;
    logic [9:0]  s_asid;
    logic        s_found, s_d, s_v;
    logic [19:0] s_ppn;
    logic [5:0]  s_ps;
    logic [1:0]  s_plv, s_mat;

    logic        t_found [16];
    logic [19:0] t_ppn   [16];
    logic [5:0]  t_ps    [16];
    logic [1:0]  t_plv   [16];
    logic [1:0]  t_mat   [16];
    logic        t_d     [16];
    logic        t_v     [16];

    logic [36:0] exp_q [$];
    int          compared = 0;
    int          mismatched = 0;
    int          rdy_mode = 0;

    addr_trans_if bus();

    addr_trans dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .bus           (bus),
        .csr_crmd_da   (c_da),
        .csr_crmd_pg   (c_pg),
        .csr_crmd_plv  (c_plv),
        .csr_crmd_datf (c_datf),
        .csr_crmd_datm (c_datm),
        .csr_asid      (c_asid),
        .csr_dmw0      (c_dmw0),
        .csr_dmw1      (c_dmw1),
        .s_vppn        (s_vppn),
        .s_va_bit12    (s_va_bit12),
        .s_asid        (s_asid),
        .s_found       (s_found),
        .s_ppn         (s_ppn),
        .s_ps          (s_ps),
        .s_plv         (s_plv),
        .s_mat         (s_mat),
        .s_d           (s_d),
        .s_v           (s_v)
    );

    assign s_found = t_found[s_vppn[3:0]];
    assign s_ppn   = t_ppn[s_vppn[3:0]];
    assign s_ps    = t_ps[s_vppn[3:0]];
    assign s_plv   = t_plv[s_vppn[3:0]];
    assign s_mat   = t_mat[s_vppn[3:0]];
    assign s_d     = t_d[s_vppn[3:0]];
    assign s_v     = t_v[s_vppn[3:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    // expected {exc, mat, pa} from the architectural translation rules
    function automatic logic [36:0] model(input logic [31:0] va, input logic [1:0] op);
        logic [31:0] d, size;
        logic [3:0]  idx;
        logic [2:0]  ex;
        if (c_da) return {3'd0, op == 2'd0 ? c_datf : c_datm, va};
        for (int w = 0; w < 2; w++) begin
            d = w == 0 ? c_dmw0 : c_dmw1;
            if (c_pg && ((c_plv == 2'd0 && d[0]) || (c_plv == 2'd3 && d[3])) && (va >> 29) == (d >> 29))
                return {3'd0, d[5:4], (32'(d[27:25]) << 29) | (va & 32'h1FFF_FFFF)};
        end
        idx = va[16:13];
        if (!t_found[idx]) ex = 3'd1;
        else if (!t_v[idx]) ex = op == 2'd0 ? 3'd4 : op == 2'd2 ? 3'd3 : 3'd2;
        else if (c_plv > t_plv[idx]) ex = 3'd6;
        else if (op == 2'd2 && !t_d[idx]) ex = 3'd5;
        else ex = 3'd0;
        if (ex != 3'd0) return {ex, 2'd0, 32'd0};
        size = 32'd1 << t_ps[idx];
        return {3'd0, t_mat[idx], ((32'(t_ppn[idx]) << 12) & ~(size - 1)) | (va & (size - 1))};
    endfunction

    task automatic set_ent(input logic [3:0] i, input logic f, input logic [19:0] ppn, input logic [5:0] ps,
                           input logic [1:0] plv, input logic [1:0] mat, input logic d, input logic v);
        t_found[i] = f; t_ppn[i] = ppn; t_ps[i] = ps; t_plv[i] = plv; t_mat[i] = mat; t_d[i] = d; t_v[i] = v;
    endtask

    // offer one request until accepted or budget expires; push expectation at handshake
    task automatic send(input logic [31:0] va, input logic [1:0] op, input logic [36:0] e,
                        input int budget, output bit acc);
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_va    = va;
            bus.req_op    = op;
            #1;
            if (bus.req_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic send_chk(input logic [31:0] va, input logic [1:0] op, input logic [36:0] e);
        bit acc;
        send(va, op, e, 50, acc);
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        chk("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic lat_chk(input logic [31:0] va, input logic [1:0] op, input logic [36:0] e);
        send_chk(va, op, e);
        chk("lat_edge_n", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge_n1", 64'(bus.rsp_valid), 64'd1);
    endtask

    // monitor: drive consumer readiness and score every delivered response
    initial begin
        logic [36:0] e;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
            #2;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_rsp: got %h with no expectation queued",
                             {bus.rsp_exc, bus.rsp_mat, bus.rsp_pa});
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", 64'({bus.rsp_exc, bus.rsp_mat, bus.rsp_pa}), 64'(e));
                end
            end
        end
    end

    initial begin
        bit          acc;
        logic [31:0] va;
        logic [1:0]  op;
        reset = 1'b1; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_va = 32'd0; bus.req_op = 2'd0;
        c_da = 1'b1; c_pg = 1'b0; c_plv = 2'd0; c_datf = 2'd2; c_datm = 2'd1;
        c_asid = 10'h2A5; c_dmw0 = 32'd0; c_dmw1 = 32'd0;
        for (int i = 0; i < 16; i++) set_ent(4'(i), 1'b0, 20'd0, 6'd12, 2'd0, 2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_out", 64'({bus.rsp_exc, bus.rsp_mat, bus.rsp_pa}), 64'd0);
        #1 reset = 1'b0;
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("s_asid", 64'(s_asid), 64'h2A5);

        rdy_mode = 0;
        lat_chk(32'h1C00_0100, 2'd1, {3'd0, 2'd1, 32'h1C00_0100});
        drain();

        c_da = 1'b0; c_pg = 1'b1; c_plv = 2'd0; c_dmw0 = 32'h8000_0011; c_dmw1 = 32'h8000_0001;
        send_chk(32'h8001_2345, 2'd1, {3'd0, 2'd1, 32'h0001_2345});
        drain();

        c_plv = 2'd3; c_dmw0 = 32'd0; c_dmw1 = 32'd0;
        set_ent(4'd0, 1'b1, 20'h12345, 6'd12, 2'd3, 2'd2, 1'b1, 1'b1);
        send_chk(32'h0040_0ABC, 2'd2, {3'd0, 2'd2, 32'h1234_5ABC});
        drain();
        t_d[0] = 1'b0;
        send_chk(32'h0040_0ABC, 2'd2, {3'd5, 2'd0, 32'd0});
        drain();
        set_ent(4'd1, 1'b1, 20'hABC00, 6'd22, 2'd3, 2'd1, 1'b1, 1'b1);
        send_chk(32'h0012_3456, 2'd1, {3'd0, 2'd1, 32'hABD2_3456});
        drain();
        t_found[0] = 1'b0;
        send_chk(32'h0040_0ABC, 2'd1, {3'd1, 2'd0, 32'd0});
        drain();
        t_found[0] = 1'b1; t_v[0] = 1'b0;
        send_chk(32'h0040_0ABC, 2'd0, {3'd4, 2'd0, 32'd0});
        drain();
        t_v[0] = 1'b1; t_plv[0] = 2'd0;
        send_chk(32'h0040_0ABC, 2'd1, {3'd6, 2'd0, 32'd0});
        drain();

        c_da = 1'b1; c_datm = 2'd1;
        rdy_mode = 2;
        send_chk(32'h1C00_0200, 2'd1, {3'd0, 2'd1, 32'h1C00_0200});
        send_chk(32'h1C00_3000, 2'd1, {3'd0, 2'd1, 32'h1C00_3000});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1; bus.req_va = 32'h1C00_4000; bus.req_op = 2'd1;
            #1;
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_rsp_hold", 64'({bus.rsp_valid, bus.rsp_exc, bus.rsp_mat, bus.rsp_pa}),
                64'({1'b1, 3'd0, 2'd1, 32'h1C00_0200}));
            chk("bp_s1_va", 64'({s_vppn, s_va_bit12}), 64'h1C003);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        do_flush();
        rdy_mode = 0;
        lat_chk(32'h1C00_5000, 2'd0, {3'd0, 2'd2, 32'h1C00_5000});
        drain();

        rdy_mode = 2;
        send_chk(32'h1C00_6000, 2'd1, {3'd0, 2'd1, 32'h1C00_6000});
        send_chk(32'h1C00_7000, 2'd1, {3'd0, 2'd1, 32'h1C00_7000});
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_rsp", 64'({bus.rsp_valid, bus.rsp_exc, bus.rsp_mat, bus.rsp_pa}), 64'd0);
        exp_q.delete();
        rdy_mode = 1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("areset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("areset_rsp_valid", 64'(bus.rsp_valid), 64'd0);

        for (int ph = 0; ph < 8; ph++) begin
            c_da   = $urandom_range(0, 4) == 0;
            c_pg   = $urandom_range(0, 3) != 0;
            c_plv  = 2'($urandom_range(0, 3));
            c_datf = 2'($urandom_range(0, 3));
            c_datm = 2'($urandom_range(0, 3));
            c_dmw0 = $urandom;
            c_dmw1 = $urandom;
            for (int i = 0; i < 16; i++)
                set_ent(4'(i), $urandom_range(0, 7) != 0, 20'($urandom), $urandom_range(0, 1) ? 6'd12 : 6'd22,
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 5) != 0);
            for (int n = 0; n < 40; n++) begin
                va = $urandom;
                case ($urandom_range(0, 3))
                    0: va[31:29] = c_dmw0[31:29];
                    1: va[31:29] = c_dmw1[31:29];
                    default: ;
                endcase
                op = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 24) == 0) do_flush();
                else begin
                    send(va, op, model(va, op), 50, acc);
                    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
            end
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
